// File: rtl/aes_key_schedule_ctrl.sv
// AES-256 round-key schedule controller: drives an external key expander and
// serves the 15 stored round keys. Optional zeroize port: AES_KEY_SCHED_ZEROIZE_EN.
module aes_key_schedule_ctrl #(
    parameter int NUM_ROUND_KEYS = 15,
    parameter int RN_WIDTH       = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Key_valid,
    output logic                Key_ready,
    input  logic [255:0]        Key,
    output logic [RN_WIDTH-1:0] Exp_round_number,
    output logic [255:0]        Exp_input_key,
    input  logic [127:0]        Exp_output_key,
    input  logic [RN_WIDTH-1:0] Rk_index,
    output logic [127:0]        Rk_data,
    output logic                Rk_valid,
    output logic                Busy,
    output logic                Done,
    output logic                Keys_ready
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    ,
    input  logic                Zeroize
`endif
);

    localparam logic [RN_WIDTH-1:0] LAST_RK  = RN_WIDTH'(NUM_ROUND_KEYS - 1);
    localparam logic [RN_WIDTH-1:0] FIRST_RN = RN_WIDTH'(2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_done_nxt;
    logic                  w_keys_ready_nxt;
    logic                  w_zeroize;
    logic                  r_done;
    logic                  r_keys_ready;
    logic [RN_WIDTH-1:0]   r_cnt;
    logic [255:0]          r_window;
    logic [127:0]          r_rk [0:NUM_ROUND_KEYS-1];
    logic [127:0]          r_rk_data;
    logic                  r_rk_valid;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    assign w_zeroize = Zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    // Next-state and control decode; zeroize overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_accept         = 1'b0;
        w_last           = 1'b0;
        w_done_nxt       = 1'b0;
        w_keys_ready_nxt = r_keys_ready;
        if (w_zeroize) begin
            w_state_nxt      = ST_IDLE;
            w_keys_ready_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_READY: begin
                    if (Key_valid) begin
                        w_accept         = 1'b1;
                        w_state_nxt      = ST_EXPAND;
                        w_keys_ready_nxt = 1'b0;
                    end else begin
                        w_accept         = 1'b0;
                    end
                end
                ST_EXPAND: begin
                    if (r_cnt == LAST_RK) begin
                        w_last           = 1'b1;
                        w_state_nxt      = ST_READY;
                        w_done_nxt       = 1'b1;
                        w_keys_ready_nxt = 1'b1;
                    end else begin
                        w_last           = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt      = ST_IDLE;
                    w_keys_ready_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state and status flags.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= ST_IDLE;
            r_done       <= 1'b0;
            r_keys_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done       <= w_done_nxt;
            r_keys_ready <= w_keys_ready_nxt;
        end
    end

    // Round counter, sliding expander window and round-key store. Counter and
    // window return to zero when expansion ends so the expander inputs go quiet.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt    <= {RN_WIDTH{1'b0}};
            r_window <= 256'h0;
            for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
                r_rk[i] <= 128'h0;
            end
        end else if (w_zeroize) begin
            r_cnt    <= {RN_WIDTH{1'b0}};
            r_window <= 256'h0;
            for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
                r_rk[i] <= 128'h0;
            end
        end else if (w_accept) begin
            r_rk[0]  <= Key[255:128];
            r_rk[1]  <= Key[127:0];
            r_window <= Key;
            r_cnt    <= FIRST_RN;
        end else if (r_state == ST_EXPAND) begin
            r_rk[r_cnt] <= Exp_output_key;
            if (w_last) begin
                r_cnt    <= {RN_WIDTH{1'b0}};
                r_window <= 256'h0;
            end else begin
                r_cnt    <= r_cnt + RN_WIDTH'(1);
                r_window <= {r_window[127:0], Exp_output_key};
            end
        end else begin
            r_cnt    <= r_cnt;
            r_window <= r_window;
        end
    end

    // Registered read port; a schedule being invalidated this cycle reads as empty.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rk_valid <= 1'b0;
            r_rk_data  <= 128'h0;
        end else if (r_keys_ready && w_keys_ready_nxt && (Rk_index <= LAST_RK)) begin
            r_rk_valid <= 1'b1;
            r_rk_data  <= r_rk[Rk_index];
        end else begin
            r_rk_valid <= 1'b0;
            r_rk_data  <= 128'h0;
        end
    end

    assign Key_ready        = (r_state != ST_EXPAND);
    assign Busy             = (r_state == ST_EXPAND);
    assign Done             = r_done;
    assign Keys_ready       = r_keys_ready;
    assign Exp_round_number = r_cnt;
    assign Exp_input_key    = r_window;
    assign Rk_data          = r_rk_data;
    assign Rk_valid         = r_rk_valid;

endmodule
